// File: rtl/device_pkg.sv
// Shared definitions for the device timer bank: register map, CTRL fields,
// MODE encodings and the per-channel FSM state encoding.
package device_pkg;

  // Word index within a channel's 16-byte window (Address[3:2]).
  localparam logic [1:0] RegCtrl     = 2'd0;
  localparam logic [1:0] RegPreset   = 2'd1;
  localparam logic [1:0] RegCount    = 2'd2;
  localparam logic [1:0] RegPrescale = 2'd3;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlImBit   = 3;
  localparam int unsigned CtrlIpBit   = 4;
  localparam int unsigned CtrlW       = 5;

  typedef enum logic [1:0] {
    ModeOneShot = 2'd0,
    ModeReload  = 2'd1,
    ModeFreeRun = 2'd2,
    ModeRsvd    = 2'd3
  } timer_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StCount = 2'd2,
    StDone  = 2'd3
  } timer_state_e;

  // The reserved encoding behaves exactly like one-shot.
  function automatic logic mode_is_oneshot(input timer_mode_e mode);
    return !((mode == ModeReload) || (mode == ModeFreeRun));
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT state and the IDLE/LOAD/COUNT/DONE FSM.
// Optional 8-bit prescaler enabled by defining TIMER_PRESCALER_EN.
module timer_channel
  import device_pkg::*;
#(
  parameter int unsigned CntW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_ctrl_i,
  input  logic             wr_preset_i,
  input  logic             wr_psc_i,
  input  logic [31:0]      wdata_i,
  output logic [CtrlW-1:0] ctrl_o,
  output logic [CntW-1:0]  preset_o,
  output logic [CntW-1:0]  count_o,
  output logic [7:0]       prescale_o,
  output logic             irq_o
);

  timer_state_e    state_q, state_d;
  timer_mode_e     mode_q, mode_d;
  logic            en_q, en_d;
  logic            im_q, im_d;
  logic            ip_q, ip_d;
  logic [CntW-1:0] preset_q, preset_d;
  logic [CntW-1:0] count_q, count_d;

  logic start, stop, tick, oneshot, free_run, at_limit, expire;

  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  // Only a 0->1 transition of EN restarts; rewriting CTRL with EN=1 keeps counting.
  assign start    = wr_ctrl_i & wdata_i[CtrlEnBit] & ~en_q;
  assign stop     = wr_ctrl_i & ~wdata_i[CtrlEnBit];
  assign oneshot  = mode_is_oneshot(mode_q);
  assign free_run = (mode_q == ModeFreeRun);
  assign at_limit = free_run ? (count_q == '1) : (count_q == '0);
  assign expire   = (state_q == StCount) & tick & ~stop & at_limit;

`ifdef TIMER_PRESCALER_EN
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] psc_q, psc_d;

  assign tick = (psc_q == prescale_q);

  always_comb begin
    prescale_d = wr_psc_i ? wdata_i[7:0] : prescale_q;
    psc_d      = psc_q;
    if (state_q == StLoad) begin
      psc_d = '0;
    end else if ((state_q == StCount) && !stop) begin
      psc_d = tick ? 8'd0 : psc_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale_q <= '0;
      psc_q      <= '0;
    end else begin
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
    end
  end

  assign prescale_o = prescale_q;
`else
  logic unused_psc;
  assign unused_psc = wr_psc_i;
  assign tick       = 1'b1;
  assign prescale_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = stop ? StIdle : StCount;
      StCount: begin
        if (stop) begin
          state_d = StIdle;
        end else if (expire && oneshot) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = start ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    ip_d     = ip_q;
    preset_d = wr_preset_i ? wdata_i[CntW-1:0] : preset_q;
    count_d  = count_q;

    if (wr_ctrl_i) begin
      en_d   = wdata_i[CtrlEnBit];
      mode_d = timer_mode_e'(wdata_i[CtrlModeMsb:CtrlModeLsb]);
      im_d   = wdata_i[CtrlImBit];
      if (wdata_i[CtrlIpBit]) ip_d = 1'b0;
    end
    // Expiry overrides a same-cycle W1C and a same-cycle EN rewrite.
    if (expire) begin
      ip_d = 1'b1;
      if (oneshot) en_d = 1'b0;
    end

    case (state_q)
      StLoad: begin
        if (!stop) count_d = free_run ? '0 : preset_q;
      end
      StCount: begin
        if (tick && !stop) begin
          if (free_run) begin
            count_d = count_q + CntW'(1);
          end else if (!at_limit) begin
            count_d = count_q - CntW'(1);
          end else if (!oneshot) begin
            count_d = preset_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      mode_q   <= ModeOneShot;
      im_q     <= 1'b0;
      ip_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      ip_q     <= ip_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  assign ctrl_o   = {ip_q, im_q, mode_q, en_q};
  assign preset_o = preset_q;
  assign count_o  = count_q;
  assign irq_o    = ip_q & im_q;

endmodule

// File: rtl/device_timer_bank.sv
// Memory-mapped bank of N_CH timers: address decode and read mux around timer_channel.
// Define TIMER_PRESCALER_EN to enable the per-channel PRESCALE register at +0xC.
module device_timer_bank
  import device_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int unsigned RD_W      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Address,
  input  logic [31:0]     writeData,
  input  logic            writeEn,
  input  logic            readEn,
  output logic [RD_W-1:0] Device_Read_Data,
  output logic [N_CH-1:0] irq
);

  logic [31:0] offset;
  logic [27:0] ch_idx;
  logic [1:0]  reg_sel;
  logic        hit;
  logic [31:0] rd_word;

  logic [CtrlW-1:0] ch_ctrl   [N_CH];
  logic [CNT_W-1:0] ch_preset [N_CH];
  logic [CNT_W-1:0] ch_count  [N_CH];
  logic [7:0]       ch_psc    [N_CH];

  assign offset  = Address - BASE_ADDR;
  assign ch_idx  = offset[31:4];
  assign reg_sel = offset[3:2];
  assign hit     = (Address >= BASE_ADDR) && (ch_idx < 28'(N_CH));

  logic unused_offset;
  assign unused_offset = ^offset[1:0];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic sel;
    assign sel = writeEn & hit & (ch_idx == 28'(k));

    timer_channel #(
      .CntW(CNT_W)
    ) u_ch (
      .clk_i      (clk),
      .rst_ni     (reset),
      .wr_ctrl_i  (sel & (reg_sel == RegCtrl)),
      .wr_preset_i(sel & (reg_sel == RegPreset)),
      .wr_psc_i   (sel & (reg_sel == RegPrescale)),
      .wdata_i    (writeData),
      .ctrl_o     (ch_ctrl[k]),
      .preset_o   (ch_preset[k]),
      .count_o    (ch_count[k]),
      .prescale_o (ch_psc[k]),
      .irq_o      (irq[k])
    );
  end

  always_comb begin
    rd_word = '0;
    if (readEn && hit) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (ch_idx == 28'(k)) begin
          case (reg_sel)
            RegCtrl:     rd_word = 32'(ch_ctrl[k]);
            RegPreset:   rd_word = 32'(ch_preset[k]);
            RegCount:    rd_word = 32'(ch_count[k]);
            RegPrescale: rd_word = 32'(ch_psc[k]);
            default:     rd_word = '0;
          endcase
        end
      end
    end
  end

  assign Device_Read_Data = RD_W'(rd_word);

endmodule

// File: tb/tb_device_timer_bank.sv
// Directed, self-checking bench for device_timer_bank (two channels, 8-bit counters).
module tb_device_timer_bank;

  localparam int unsigned NCh  = 2;
  localparam int unsigned CntW = 8;

  localparam logic [31:0] Ch0Ctrl   = 32'h0000_7F00;
  localparam logic [31:0] Ch0Preset = 32'h0000_7F04;
  localparam logic [31:0] Ch0Count  = 32'h0000_7F08;
  localparam logic [31:0] Ch0Psc    = 32'h0000_7F0C;
  localparam logic [31:0] Ch1Ctrl   = 32'h0000_7F10;
  localparam logic [31:0] Ch1Preset = 32'h0000_7F14;
  localparam logic [31:0] Ch1Count  = 32'h0000_7F18;

`ifdef TIMER_PRESCALER_EN
  localparam logic [31:0] PscReadAb = 32'h0000_00AB;
  localparam logic [31:0] PscRead2  = 32'h0000_0002;
  localparam int          OsExpiry  = 10;
`else
  localparam logic [31:0] PscReadAb = 32'h0000_0000;
  localparam logic [31:0] PscRead2  = 32'h0000_0000;
  localparam int          OsExpiry  = 4;
`endif

  logic            clk;
  logic            reset;
  logic [31:0]     Address;
  logic [31:0]     writeData;
  logic            writeEn;
  logic            readEn;
  logic [31:0]     Device_Read_Data;
  logic [NCh-1:0]  irq;

  int n_tests = 0;
  int n_fail  = 0;

  device_timer_bank #(
    .N_CH     (NCh),
    .CNT_W    (CntW),
    .BASE_ADDR(32'h0000_7F00),
    .RD_W     (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Address         (Address),
    .writeData       (writeData),
    .writeEn         (writeEn),
    .readEn          (readEn),
    .Device_Read_Data(Device_Read_Data),
    .irq             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    writeData = d;
    writeEn   = 1'b1;
    @(posedge clk);
    #1;
    writeEn   = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    Address = a;
    readEn  = 1'b1;
    #1;
    chk(name, Device_Read_Data, exp);
    readEn  = 1'b0;
  endtask

  task automatic irq_chk(input string name, input logic [NCh-1:0] exp);
    chk(name, 32'(irq), 32'(exp));
  endtask

  initial begin
    reset = 1'b0; Address = '0; writeData = '0; writeEn = 1'b0; readEn = 1'b0;
    #1;
    irq_chk("rst_irq_async", '0);
    #11 reset = 1'b1;
    step(1);

    vecs.push_back(mk("rst_ctrl0",     1'b0, Ch0Ctrl,      32'h0,    32'h0));
    vecs.push_back(mk("rst_preset0",   1'b0, Ch0Preset,    32'h0,    32'h0));
    vecs.push_back(mk("rst_count0",    1'b0, Ch0Count,     32'h0,    32'h0));
    vecs.push_back(mk("rst_ctrl1",     1'b0, Ch1Ctrl,      32'h0,    32'h0));
    vecs.push_back(mk("ctrl_ip_ro",    1'b1, Ch0Ctrl,      32'h1E,   32'h0E));
    vecs.push_back(mk("preset_trunc",  1'b1, Ch0Preset,    32'h1234, 32'h34));
    vecs.push_back(mk("count_ro",      1'b1, Ch0Count,     32'h55,   32'h0));
    vecs.push_back(mk("prescale_rw",   1'b1, Ch0Psc,       32'hAB,   PscReadAb));
    vecs.push_back(mk("addr_lsb_ign",  1'b0, 32'h7F06,     32'h0,    32'h34));
    vecs.push_back(mk("preset1",       1'b1, Ch1Preset,    32'h77,   32'h77));
    vecs.push_back(mk("ch_isolation",  1'b0, Ch0Preset,    32'h0,    32'h34));
    vecs.push_back(mk("unmapped_hi",   1'b1, 32'h7F20,     32'hFF,   32'h0));
    vecs.push_back(mk("unmapped_lo",   1'b0, 32'h7EFC,     32'h0,    32'h0));
    vecs.push_back(mk("ctrl1_im",      1'b1, Ch1Ctrl,      32'h08,   32'h08));
    vecs.push_back(mk("ctrl0_clear",   1'b1, Ch0Ctrl,      32'h00,   32'h00));

    foreach (vecs[i]) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end
    irq_chk("irq_idle", '0);

    Address = Ch1Preset; readEn = 1'b0; #1;
    chk("read_disabled", Device_Read_Data, 32'h0);

    wr(Ch0Psc, 32'h0);

    // One-shot: PRESET=5 counts 5..0, expires on the 7th edge after the CTRL write.
    wr(Ch0Preset, 32'd5);
    wr(Ch0Ctrl, 32'h09);
    for (int i = 0; i < 6; i++) begin
      step(1);
      rd_chk("os_count", Ch0Count, 32'(5 - i));
      irq_chk("os_irq_pre", '0);
    end
    step(1);
    irq_chk("os_irq", 2'b01);
    rd_chk("os_ctrl_done", Ch0Ctrl, 32'h18);
    rd_chk("os_count_hold", Ch0Count, 32'h0);
    wr(Ch0Ctrl, 32'h18);
    irq_chk("os_w1c", '0);

    // Auto-reload: PRESET=3 gives 3,2,1,0,3 with expiry on the reload edge.
    wr(Ch0Preset, 32'd3);
    wr(Ch0Ctrl, 32'h0B);
    for (int i = 0; i < 5; i++) begin
      step(1);
      rd_chk("ar_count", Ch0Count, (i == 4) ? 32'd3 : 32'(3 - i));
      irq_chk("ar_irq", (i == 4) ? 2'b01 : 2'b00);
    end
    wr(Ch0Ctrl, 32'h1B);
    rd_chk("ar_w1c_ctrl", Ch0Ctrl, 32'h0B);
    irq_chk("ar_w1c_irq", '0);
    rd_chk("ar_keeps_counting", Ch0Count, 32'd2);
    step(3);
    rd_chk("ar_reload2", Ch0Count, 32'd3);
    irq_chk("ar_irq2", 2'b01);
    wr(Ch0Ctrl, 32'h10);
    rd_chk("stop_freeze", Ch0Count, 32'd3);
    step(3);
    rd_chk("stop_frozen", Ch0Count, 32'd3);
    rd_chk("stop_ctrl", Ch0Ctrl, 32'h0);

    // Collisions: PRESET write and W1C on expiry edges.
    wr(Ch0Preset, 32'd2);
    wr(Ch0Ctrl, 32'h0B);
    step(3);
    rd_chk("col_count0", Ch0Count, 32'd0);
    wr(Ch0Preset, 32'd9);
    rd_chk("col_old_reload", Ch0Count, 32'd2);
    rd_chk("col_new_preset", Ch0Preset, 32'd9);
    irq_chk("col_irq", 2'b01);
    wr(Ch0Ctrl, 32'h1B);
    irq_chk("col_w1c", '0);
    step(1);
    rd_chk("col_count1", Ch0Count, 32'd0);
    wr(Ch0Ctrl, 32'h1B);
    rd_chk("col_new_reload", Ch0Count, 32'd9);
    irq_chk("col_set_wins", 2'b01);
    rd_chk("col_ctrl", Ch0Ctrl, 32'h1B);
    wr(Ch0Ctrl, 32'h10);

    // Free-run on channel 1: 0..255, wrap sets IP, masked irq stays low.
    wr(Ch1Ctrl, 32'h05);
    for (int i = 0; i < 256; i++) begin
      step(1);
      rd_chk("fr_count", Ch1Count, 32'(i));
    end
    rd_chk("fr_no_ip", Ch1Ctrl, 32'h05);
    step(1);
    rd_chk("fr_wrap", Ch1Count, 32'h0);
    rd_chk("fr_ip", Ch1Ctrl, 32'h15);
    irq_chk("fr_masked", '0);
    wr(Ch1Ctrl, 32'h0D);
    irq_chk("fr_unmasked", 2'b10);
    wr(Ch1Ctrl, 32'h08);
    rd_chk("fr_stop", Ch1Ctrl, 32'h18);

    // PRESET=0: expiry one edge after LOAD.
    wr(Ch0Preset, 32'd0);
    wr(Ch0Ctrl, 32'h09);
    step(1);
    irq_chk("p0_after_load", 2'b10);
    step(1);
    irq_chk("p0_expired", 2'b11);
    rd_chk("p0_ctrl", Ch0Ctrl, 32'h18);
    wr(Ch0Ctrl, 32'h18);

    // One-shot PRESET=2 with PRESCALE=2 (prescale ignored when the feature is absent).
    wr(Ch0Psc, 32'd2);
    rd_chk("psc_read", Ch0Psc, PscRead2);
    wr(Ch0Preset, 32'd2);
    wr(Ch0Ctrl, 32'h09);
    for (int i = 1; i <= OsExpiry; i++) begin
      step(1);
      irq_chk("psc_expiry", (i == OsExpiry) ? 2'b11 : 2'b10);
    end
    wr(Ch0Ctrl, 32'h18);
    wr(Ch0Psc, 32'd0);

    // Reset mid-count clears everything without a clock edge.
    wr(Ch0Preset, 32'd6);
    wr(Ch0Ctrl, 32'h09);
    step(4);
    rd_chk("rm_count3", Ch0Count, 32'd3);
    irq_chk("rm_irq_before", 2'b10);
    #2 reset = 1'b0;
    #1;
    irq_chk("rm_irq", '0);
    rd_chk("rm_ctrl0", Ch0Ctrl, 32'h0);
    rd_chk("rm_count0", Ch0Count, 32'h0);
    rd_chk("rm_preset0", Ch0Preset, 32'h0);
    rd_chk("rm_ctrl1", Ch1Ctrl, 32'h0);
    Address = Ch0Preset; writeData = 32'h44; writeEn = 1'b1;
    @(posedge clk);
    #1;
    writeEn = 1'b0;
    reset   = 1'b1;
    rd_chk("rm_write_dropped", Ch0Preset, 32'h0);
    step(2);
    rd_chk("rm_stays_idle", Ch0Count, 32'h0);
    irq_chk("rm_irq_after", '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
